parity_link_scheduler: RTL and testbench
========================================

Name: parity_link_scheduler

Overview:
- Sequencing controller that shares one 4-bit parity encode/noise/check datapath between two requesters.
- Arbitrates round-robin and latches the granted word. Builds a 5-bit framed word with even or odd parity, optionally corrupting one bit.
- Checks the received frame and retransmits on a detected parity error, up to a retry limit.
- Returns a per-requester ack with pass/fail status and keeps a saturating error counter for test/debug.

Parameters:
- MAX_RETRY, 2, number of retransmissions allowed after the first failed check (0 means no retry).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  2  request per requester; held high until the matching ack.
- data0  input  4  requester 0 payload; sampled at grant.
- data1  input  4  requester 1 payload; sampled at grant.
- odd_sel  input  1  parity mode, sampled at grant: 0 = even, 1 = odd.
- noise_en  input  1  enables bit-flip injection; sampled every TX cycle.
- noise_pos  input  3  bit index to flip (0 = parity bit, 1..4 = A[0..3]); values 5..7 mean no flip.
- grant  output  2  one-hot owner of the datapath; 0 when idle.
- frame_out  output  5  transmitted frame {data, parity_bit} after noise.
- frame_valid  output  1  high for the TX cycle only.
- ack  output  2  one-cycle completion pulse to the owner.
- ack_ok  output  1  qualifies ack: 1 = passed check, 0 = retries exhausted.
- err_detected  output  1  one-cycle pulse in CHECK when parity fails.
- retry_cnt  output  2  retries used in the current transaction.
- err_count  output  CNT_W  saturating count of all detected errors.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate): state IDLE. Clear grant, frame_out, frame_valid, ack, ack_ok, err_detected, retry_cnt, err_count. Round-robin pointer last = 1, so requester 0 wins the first tie.
- States: IDLE, TX, CHECK, ACK.
- IDLE:
  - If req != 0, choose the owner. A single request wins. If both request, the owner is the one not equal to last.
  - Latch the owner's data and odd_sel, set grant one-hot, clear retry_cnt, go to TX.
  - If req == 0, stay in IDLE.
- TX (1 cycle):
  - frame_valid = 1.
  - parity_bit = (^data) XOR odd_sel, so total ones are even for even mode and odd for odd mode.
  - If noise_en = 1 and noise_pos < 5, flip bit noise_pos of the frame. Register the frame and go to CHECK.
- CHECK (1 cycle):
  - Check fails when (^frame) XOR odd_sel = 1.
  - On fail: pulse err_detected and increment err_count, holding at all-ones.
  - Fail with retry_cnt < MAX_RETRY: retry_cnt++, go back to TX.
  - Fail with retries exhausted: go to ACK with ack_ok = 0.
  - Pass: go to ACK with ack_ok = 1.
- ACK (1 cycle): ack[owner] = 1, ack_ok valid, last = owner, grant cleared on exit, go to IDLE.
- Latency: a request sampled in IDLE at edge N gives TX during cycle N+1, CHECK N+2 and ack N+3. Each retry adds 2 cycles.
- Simultaneous events:
  - req deasserted mid-transaction is ignored; the transaction completes and acks anyway.
  - A new or still-held request is not re-evaluated until IDLE, so there is at least one idle cycle between transactions.
- Double-bit errors are undetectable by design and pass with ack_ok = 1.
- Reset mid-transaction aborts with no ack and returns to IDLE.
- err_count is never cleared except by rst.

Decomposition:
- Shared package parity_pkg holds:
  - the state enum;
  - FRAME_W = 5 and DATA_W = 4;
  - NOISE_NONE threshold 5;
  - a parity-bit function (data, odd_sel) and a frame-check function (frame, odd_sel).
- One natural sub-module, parity_frame_codec: combinational encode + noise flip + check, instanced once.
- Arbiter and FSM stay in the top.

Test Plan:
- Reset then req=01, data0=4'b1011, odd_sel=0, noise_en=0 -> frame_out=5'b10111, frame_valid in cycle N+1, ack=01 with ack_ok=1 at N+3, err_count=0.
- req=11 held from reset -> first grant=01; after ack, grant=10; then alternates 01/10 each transaction.
- data1=4'b0000, odd_sel=1, noise_en=1, noise_pos=2, MAX_RETRY=2 -> err_detected pulses 3 times, retry_cnt reaches 2, ack=10 with ack_ok=0 at N+7, err_count=3.
- noise_en=1 for the first TX only, then 0 -> one err_detected, retry_cnt=1, ack_ok=1 at N+5.
- noise_pos=6 with noise_en=1 -> no flip, pass in 3 cycles; force err_count to saturate (CNT_W=2) -> holds at 3.
- Assert rst during CHECK -> all outputs 0 immediately, no ack; next request served normally with requester 0 preferred.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types, widths and parity helpers for the parity link scheduler.
package parity_pkg;

    localparam int DATA_W  = 4;
    localparam int FRAME_W = 5;

    // Noise positions at or above this value leave the frame untouched.
    localparam logic [2:0] NOISE_NONE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TX    = 2'd1,
        ST_CHECK = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Parity bit that makes the total number of ones even (odd_sel=0) or odd (odd_sel=1).
    function automatic logic calc_parity(input logic [DATA_W-1:0] data, input logic odd_sel);
        return (^data) ^ odd_sel;
    endfunction

    // Returns 1 when the frame does not have the parity selected by odd_sel.
    function automatic logic frame_fails(input logic [FRAME_W-1:0] frame, input logic odd_sel);
        return (^frame) ^ odd_sel;
    endfunction

endpackage

// File: rtl/parity_frame_codec.sv
// Combinational frame encoder with optional single-bit corruption, plus the receive-side check.
module parity_frame_codec
    import parity_pkg::*;
(
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_odd_sel,
    input  logic               i_noise_en,
    input  logic [2:0]         i_noise_pos,
    input  logic [FRAME_W-1:0] i_rx_frame,
    output logic [FRAME_W-1:0] o_tx_frame,
    output logic               o_check_fail
);

    logic [FRAME_W-1:0] w_flip_mask;

    // Build the flip mask; bit 0 is the parity bit, bits 1..4 carry the payload.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_flip_mask = '0;
        if (i_noise_en && (i_noise_pos < NOISE_NONE)) begin
            w_flip_mask = FRAME_W'(1) << i_noise_pos;
        end
    end

    assign o_tx_frame   = {i_data, calc_parity(i_data, i_odd_sel)} ^ w_flip_mask;
    assign o_check_fail = frame_fails(i_rx_frame, i_odd_sel);

endmodule

// File: rtl/parity_link_scheduler.sv
// Round-robin scheduler sharing one parity encode/noise/check datapath between two requesters.
module parity_link_scheduler
    import parity_pkg::*;
#(
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [DATA_W-1:0]  data0,
    input  logic [DATA_W-1:0]  data1,
    input  logic               odd_sel,
    input  logic               noise_en,
    input  logic [2:0]         noise_pos,
    output logic [1:0]         grant,
    output logic [FRAME_W-1:0] frame_out,
    output logic               frame_valid,
    output logic [1:0]         ack,
    output logic               ack_ok,
    output logic               err_detected,
    output logic [1:0]         retry_cnt,
    output logic [CNT_W-1:0]   err_count,
    output logic               busy
);

    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRY);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_owner;
    logic               r_last;
    logic [DATA_W-1:0]  r_data;
    logic               r_odd;
    logic [FRAME_W-1:0] r_frame;
    logic [1:0]         r_retry;
    logic [1:0]         r_grant;
    logic               r_ack_ok;
    logic [CNT_W-1:0]   r_err_count;

    logic               w_pick;
    logic [FRAME_W-1:0] w_tx_frame;
    logic               w_check_fail;
    logic               w_can_retry;

    // A lone request wins; on a tie the requester that was not served last wins.
    assign w_pick      = (req == 2'b10) ? 1'b1 : (req == 2'b01) ? 1'b0 : ~r_last;
    assign w_can_retry = (r_retry < RETRY_LIMIT);

    parity_frame_codec u_codec (
        .i_data       (r_data),
        .i_odd_sel    (r_odd),
        .i_noise_en   (noise_en),
        .i_noise_pos  (noise_pos),
        .i_rx_frame   (r_frame),
        .o_tx_frame   (w_tx_frame),
        .o_check_fail (w_check_fail)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_next_state = r_state;
        frame_valid  = 1'b0;
        frame_out    = r_frame;
        err_detected = 1'b0;
        ack          = 2'b00;
        ack_ok       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (req != 2'b00) w_next_state = ST_TX;
            end
            ST_TX: begin
                frame_valid  = 1'b1;
                frame_out    = w_tx_frame;
                w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                err_detected = w_check_fail;
                w_next_state = (w_check_fail && w_can_retry) ? ST_TX : ST_ACK;
            end
            ST_ACK: begin
                ack          = r_owner ? 2'b10 : 2'b01;
                ack_ok       = r_ack_ok;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Transaction datapath: grant latch, frame capture, retry and error bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_data      <= '0;
            r_odd       <= 1'b0;
            r_frame     <= '0;
            r_retry     <= '0;
            r_grant     <= '0;
            r_ack_ok    <= 1'b0;
            r_err_count <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        r_owner <= w_pick;
                        r_grant <= w_pick ? 2'b10 : 2'b01;
                        r_data  <= w_pick ? data1 : data0;
                        r_odd   <= odd_sel;
                        r_retry <= '0;
                    end
                end
                ST_TX: begin
                    r_frame <= w_tx_frame;
                end
                ST_CHECK: begin
                    r_ack_ok <= ~w_check_fail;
                    if (w_check_fail) begin
                        if (r_err_count != {CNT_W{1'b1}}) r_err_count <= r_err_count + CNT_W'(1);
                        if (w_can_retry) r_retry <= r_retry + 2'd1;
                    end
                end
                ST_ACK: begin
                    r_last  <= r_owner;
                    r_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign grant     = r_grant;
    assign retry_cnt = r_retry;
    assign err_count = r_err_count;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_parity_link_scheduler.sv
// Self-checking bench: directed vector table, reset-abort sequence, random and saturation runs.
module tb_parity_link_scheduler;

    localparam int MAXR = 2;
    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] data0, data1;
    logic       odd_sel, noise_en;
    logic [2:0] noise_pos;
    logic [1:0] grant, ack, retry_cnt;
    logic [4:0] frame_out;
    logic       frame_valid, ack_ok, err_detected, busy;
    logic [7:0] err_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_last = 1;
    int m_err  = 0;

    always #5 clk = ~clk;

    parity_link_scheduler #(.MAX_RETRY(MAXR), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .odd_sel(odd_sel), .noise_en(noise_en), .noise_pos(noise_pos),
        .grant(grant), .frame_out(frame_out), .frame_valid(frame_valid),
        .ack(ack), .ack_ok(ack_ok), .err_detected(err_detected),
        .retry_cnt(retry_cnt), .err_count(err_count), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: payload above a parity bit chosen by counting ones, then the optional flip.
    function automatic logic [4:0] model_frame(input logic [3:0] d, input logic odd,
                                               input logic en, input logic [2:0] pos);
        logic [4:0] f;
        int ones = $countones(d);
        logic p = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        f = {d, p};
        if (en && pos < 5) f[pos] = ~f[pos];
        return f;
    endfunction

    // Runs one transaction from an IDLE cycle; nz packs {en,pos} per attempt, attempt 0 in [3:0].
    task automatic run_txn(input logic [1:0] rq, input logic [3:0] d0, input logic [3:0] d1,
                           input logic odd, input logic [11:0] nz, input bit drop,
                           output int o_owner, output int o_errs, output int o_cycles,
                           output logic o_ok, output logic [4:0] o_frame0);
        int         exp_owner, att, cyc;
        logic [3:0] edata, nzv;
        logic       exp_flip, prev_tx, done;
        req = rq; data0 = d0; data1 = d1; odd_sel = odd; noise_en = 1'b0; noise_pos = 3'd7;
        #1;
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 0);
        exp_owner = (rq == 2'b01) ? 0 : (rq == 2'b10) ? 1 : ((m_last == 0) ? 1 : 0);
        edata = exp_owner ? d1 : d0;
        att = 0; cyc = 0; exp_flip = 1'b0; prev_tx = 1'b0; done = 1'b0;
        o_owner = -1; o_errs = 0; o_ok = 1'b0; o_frame0 = '0;
        @(negedge clk);
        while (!done && cyc < 20) begin
            nzv = nz[4*((att > 2) ? 2 : att) +: 4];
            noise_en = nzv[3]; noise_pos = nzv[2:0];
            #1;
            cyc++;
            if (err_detected) o_errs++;
            if (prev_tx) begin
                check("chk_err_detected", err_detected, exp_flip);
                check("chk_frame_valid", frame_valid, 0);
                if (exp_flip && m_err < CMAX) m_err++;
            end
            if (frame_valid) begin
                if (att == 0) begin
                    o_frame0 = frame_out;
                    o_owner  = (grant == 2'b10) ? 1 : (grant == 2'b01) ? 0 : -1;
                    if (drop) req = 2'b00;
                end
                exp_flip = noise_en && (noise_pos < 3'd5);
                check("tx_frame", frame_out, model_frame(edata, odd, noise_en, noise_pos));
                check("tx_retry", retry_cnt, att);
                att++;
            end
            prev_tx = frame_valid;
            if (ack != 2'b00) begin
                done = 1'b1;
                o_ok = ack_ok;
                check("ack_owner", ack, exp_owner ? 2'b10 : 2'b01);
                check("ack_ok", ack_ok, !exp_flip);
                check("ack_err_count", err_count, m_err);
                check("ack_grant", grant, exp_owner ? 2'b10 : 2'b01);
            end
            @(negedge clk);
        end
        check("ack_seen", done, 1);
        o_cycles = cyc;
        m_last   = exp_owner;
        req = 2'b00; noise_en = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  rq;
        logic [3:0]  d0, d1;
        logic        odd;
        logic [11:0] nz;
        int          e_owner, e_errs, e_cycles;
        logic        e_ok;
        logic [4:0]  e_frame0;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         own, errs, cyc;
        logic       ok;
        logic [4:0] f0;

        vecs[0] = '{2'b01, 4'b1011, 4'b0000, 1'b0, 12'h000, 0, 0, 3, 1'b1, 5'b10111};
        vecs[1] = '{2'b11, 4'b0000, 4'b0000, 1'b1, 12'hAAA, 1, 3, 7, 1'b0, 5'b00101};
        vecs[2] = '{2'b11, 4'b0101, 4'b1111, 1'b0, 12'h00C, 0, 1, 5, 1'b1, 5'b11010};
        vecs[3] = '{2'b11, 4'b0000, 4'b1111, 1'b0, 12'hEEE, 1, 0, 3, 1'b1, 5'b11110};
        vecs[4] = '{2'b10, 4'b0000, 4'b0110, 1'b1, 12'h000, 1, 0, 3, 1'b1, 5'b01101};
        vecs[5] = '{2'b01, 4'b1000, 4'b0000, 1'b1, 12'h088, 0, 2, 7, 1'b1, 5'b10001};
        vecs[6] = '{2'b11, 4'b0000, 4'b1001, 1'b0, 12'h000, 1, 0, 3, 1'b1, 5'b10010};

        rst = 1'b1; req = 2'b00; data0 = '0; data1 = '0;
        odd_sel = 1'b0; noise_en = 1'b0; noise_pos = 3'd7;
        @(negedge clk); @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_frame_out", frame_out, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_ack", ack, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        foreach (vecs[i]) begin
            run_txn(vecs[i].rq, vecs[i].d0, vecs[i].d1, vecs[i].odd, vecs[i].nz, 1'b0,
                    own, errs, cyc, ok, f0);
            check($sformatf("v%0d_owner", i), own, vecs[i].e_owner);
            check($sformatf("v%0d_errs", i), errs, vecs[i].e_errs);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].e_cycles);
            check($sformatf("v%0d_ok", i), ok, vecs[i].e_ok);
            check($sformatf("v%0d_frame0", i), f0, vecs[i].e_frame0);
        end
        check("table_err_count", err_count, 6);

        // Reset during CHECK aborts the transaction and restores requester 0 priority.
        req = 2'b01; data0 = 4'b0011; odd_sel = 1'b0; noise_en = 1'b1; noise_pos = 3'd1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_in_check", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_grant", grant, 0);
        check("abort_frame_out", frame_out, 0);
        check("abort_err_detected", err_detected, 0);
        check("abort_ack", ack, 0);
        check("abort_retry", retry_cnt, 0);
        check("abort_err_count", err_count, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        check("abort_no_ack", ack, 0);
        rst = 1'b0; req = 2'b00; noise_en = 1'b0;
        m_last = 1; m_err = 0;
        @(negedge clk);
        run_txn(2'b11, 4'b0110, 4'b1100, 1'b1, 12'h000, 1'b0, own, errs, cyc, ok, f0);
        check("post_abort_owner", own, 0);
        check("post_abort_cycles", cyc, 3);

        // Randomised transactions against the model, including early req drop.
        for (int k = 0; k < 150; k++) begin
            logic [11:0] nz;
            nz = '0;
            for (int a = 0; a < 3; a++) begin
                nz[4*a+3]   = ($urandom_range(0, 2) == 0);
                nz[4*a +: 3] = 3'($urandom_range(0, 7));
            end
            run_txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 1'($urandom),
                    nz, 1'($urandom), own, errs, cyc, ok, f0);
        end

        // Drive enough failures to reach and hold saturation.
        for (int k = 0; k < 90; k++) begin
            run_txn(2'b11, 4'($urandom), 4'($urandom), 1'($urandom), 12'h888, 1'b0,
                    own, errs, cyc, ok, f0);
        end
        check("saturated_err_count", err_count, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
